// File: rtl/wb_stage.sv
// Writeback stage: aligns load data, selects the writeback source, drives the
// register-file write port, and produces the registered difftest trace and retire counter.
module wb_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             stall,
   input  logic             refresh,
   input  logic [31:0]      wb_data_rdata,
   input  logic [31:0]      wb_pc,
   input  logic [31:0]      wb_inst,
   input  logic [31:0]      wb_res,
   input  logic             wb_load,
   input  logic             wb_loadX,
   input  logic [3:0]       wb_lsV,
   input  logic [1:0]       wb_data_addr,
   input  logic             wb_al,
   input  logic             wb_regwen,
   input  logic [4:0]       wb_wreg,
   input  logic             wb_data_req,
   input  logic             wb_eret,
   input  logic             wb_cp0ren,
   input  logic [31:0]      wb_cp0rdata,
   input  logic [1:0]       wb_hiloren,
   input  logic [31:0]      wb_hilordata,
   output logic             rf_wen,
   output logic [4:0]       rf_waddr,
   output logic [31:0]      rf_wdata,
   output logic [31:0]      debug_wb_pc,
   output logic [3:0]       debug_wb_rf_wen,
   output logic [4:0]       debug_wb_rf_wnum,
   output logic [31:0]      debug_wb_rf_wdata,
   output logic [CNT_W-1:0] retire_cnt
);

   logic        valid;
   logic        done;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;

   // The instruction word and eret flag only travel with the slot for tracing upstream.
   logic unused_trace;
   assign unused_trace = ^{wb_inst, wb_eret};

   assign valid = (wb_pc != RESET_PC);

   always_comb begin
      case (wb_data_addr)
         2'b01:   ld_byte = wb_data_rdata[15:8];
         2'b10:   ld_byte = wb_data_rdata[23:16];
         2'b11:   ld_byte = wb_data_rdata[31:24];
         default: ld_byte = wb_data_rdata[7:0];
      endcase
      ld_half = wb_data_addr[1] ? wb_data_rdata[31:16] : wb_data_rdata[15:0];
      case (wb_lsV)
         4'b0001: ld_data = {{24{wb_loadX & ld_byte[7]}}, ld_byte};
         4'b0011: ld_data = {{16{wb_loadX & ld_half[15]}}, ld_half};
         default: ld_data = wb_data_rdata;
      endcase
   end

   always_comb begin
      if (wb_load)
         rf_wdata = ld_data;
      else if (wb_al)
         rf_wdata = wb_pc + 32'd8;
      else if (wb_cp0ren)
         rf_wdata = wb_cp0rdata;
      else if (wb_hiloren != 2'b00)
         rf_wdata = wb_hilordata;
      else
         rf_wdata = wb_res;
   end

   // done suppresses repeat writes/retires while the segment holds the same slot.
   assign rf_wen   = valid & wb_regwen & (wb_wreg != 5'd0) & ~done & ~(wb_load & ~wb_data_req);
   assign rf_waddr = wb_wreg;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         done <= 1'b0;
      else if (refresh || !stall)
         done <= 1'b0;
      else if (valid)
         done <= 1'b1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         retire_cnt <= '0;
      else if (valid && !done)
         retire_cnt <= retire_cnt + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         debug_wb_pc       <= '0;
         debug_wb_rf_wen   <= '0;
         debug_wb_rf_wnum  <= '0;
         debug_wb_rf_wdata <= '0;
      end else begin
         debug_wb_pc       <= (valid && !done) ? wb_pc : '0;
         debug_wb_rf_wen   <= {4{rf_wen}};
         debug_wb_rf_wnum  <= rf_wen ? wb_wreg : '0;
         debug_wb_rf_wdata <= rf_wen ? rf_wdata : '0;
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: spec-level model plus per-cycle compare and literal pins.
module tb_wb_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] res;
      logic [31:0] rdata;
      logic        load;
      logic        loadX;
      logic [3:0]  lsV;
      logic [1:0]  addr;
      logic        al;
      logic        regwen;
      logic [4:0]  wreg;
      logic        req;
      logic        eret;
      logic        cp0ren;
      logic [31:0] cp0rdata;
      logic [1:0]  hiloren;
      logic [31:0] hilordata;
   } instr_t;

   logic clk = 1'b0;
   logic resetn = 1'b1;
   logic stall = 1'b0;
   logic refresh = 1'b0;
   instr_t cur = '0;
   logic cur_first = 1'b1;

   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] debug_wb_pc;
   logic [3:0]  debug_wb_rf_wen;
   logic [4:0]  debug_wb_rf_wnum;
   logic [31:0] debug_wb_rf_wdata;
   logic [3:0]  retire_cnt;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wb_stage #(.RESET_PC(RESET_PC), .CNT_W(4)) dut (
      .clk(clk), .resetn(resetn), .stall(stall), .refresh(refresh),
      .wb_data_rdata(cur.rdata), .wb_pc(cur.pc), .wb_inst(cur.inst), .wb_res(cur.res),
      .wb_load(cur.load), .wb_loadX(cur.loadX), .wb_lsV(cur.lsV), .wb_data_addr(cur.addr),
      .wb_al(cur.al), .wb_regwen(cur.regwen), .wb_wreg(cur.wreg), .wb_data_req(cur.req),
      .wb_eret(cur.eret), .wb_cp0ren(cur.cp0ren), .wb_cp0rdata(cur.cp0rdata),
      .wb_hiloren(cur.hiloren), .wb_hilordata(cur.hilordata),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
      .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
      .retire_cnt(retire_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected writeback value from the instruction's architectural meaning.
   function automatic logic [31:0] m_wdata(input instr_t i);
      logic [31:0] v;
      if (i.load) begin
         if (i.lsV == 4'b0001) begin
            v = (i.rdata >> (i.addr * 5'd8)) & 32'h0000_00FF;
            if (i.loadX && v[7]) v = v | 32'hFFFF_FF00;
         end else if (i.lsV == 4'b0011) begin
            v = (i.rdata >> (i.addr[1] ? 16 : 0)) & 32'h0000_FFFF;
            if (i.loadX && v[15]) v = v | 32'hFFFF_0000;
         end else begin
            v = i.rdata;
         end
      end else if (i.al)                v = i.pc + 32'd8;
      else if (i.cp0ren)                v = i.cp0rdata;
      else if (i.hiloren != 2'b00)      v = i.hilordata;
      else                              v = i.res;
      return v;
   endfunction

   function automatic logic m_wen(input instr_t i, input logic first);
      return (i.pc != RESET_PC) && i.regwen && (i.wreg != 5'd0) && first && !(i.load && !i.req);
   endfunction

   logic [3:0]  m_cnt;
   logic [31:0] m_dpc;
   logic [3:0]  m_dwen;
   logic [4:0]  m_dwnum;
   logic [31:0] m_dwdata;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_cnt <= 4'd0; m_dpc <= '0; m_dwen <= '0; m_dwnum <= '0; m_dwdata <= '0;
      end else begin
         if ((cur.pc != RESET_PC) && cur_first) m_cnt <= m_cnt + 4'd1;
         m_dpc    <= ((cur.pc != RESET_PC) && cur_first) ? cur.pc : 32'd0;
         m_dwen   <= m_wen(cur, cur_first) ? 4'hF : 4'h0;
         m_dwnum  <= m_wen(cur, cur_first) ? cur.wreg : 5'd0;
         m_dwdata <= m_wen(cur, cur_first) ? m_wdata(cur) : 32'd0;
      end
   end

   always @(negedge clk) begin
      chk("rf_wen", rf_wen, m_wen(cur, cur_first));
      chk("rf_waddr", rf_waddr, cur.wreg);
      chk("rf_wdata", rf_wdata, m_wdata(cur));
      chk("debug_wb_pc", debug_wb_pc, m_dpc);
      chk("debug_wb_rf_wen", debug_wb_rf_wen, m_dwen);
      chk("debug_wb_rf_wnum", debug_wb_rf_wnum, m_dwnum);
      chk("debug_wb_rf_wdata", debug_wb_rf_wdata, m_dwdata);
      chk("retire_cnt", retire_cnt, m_cnt);
   end

   function automatic instr_t base(input logic [31:0] pc, input logic [4:0] wreg, input logic [31:0] res);
      instr_t i;
      i = '0;
      i.pc = pc; i.inst = pc ^ 32'h1234_5678; i.res = res;
      i.lsV = 4'b1111; i.regwen = 1'b1; i.wreg = wreg;
      return i;
   endfunction

   function automatic instr_t ld(input logic [31:0] pc, input logic [4:0] wreg, input logic [31:0] rdata,
                                 input logic [3:0] lsV, input logic [1:0] addr, input logic sx);
      instr_t i;
      i = base(pc, wreg, 32'h0000_1000);
      i.load = 1'b1; i.req = 1'b1; i.rdata = rdata; i.lsV = lsV; i.addr = addr; i.loadX = sx;
      return i;
   endfunction

   // One slot: first cycle fresh, then nhold stalled cycles; optionally ends with refresh+stall.
   task automatic slot(input instr_t ins, input int unsigned nhold, input logic endref,
                       input logic lit, input logic lw, input logic [31:0] lwd);
      for (int unsigned k = 0; k <= nhold; k++) begin
         cur = ins;
         cur_first = (k == 0);
         stall = (k < nhold) ? 1'b1 : endref;
         refresh = (k < nhold) ? 1'b0 : endref;
         if (lit && k == 0) begin
            #1;
            chk("lit_wen", rf_wen, lw);
            chk("lit_wdata", rf_wdata, lwd);
         end
         if (lit && k == 1) begin
            #1;
            chk("lit_hold_wen", rf_wen, 1'b0);
         end
         @(posedge clk); #1;
      end
      stall = 1'b0; refresh = 1'b0;
   endtask

   instr_t t;

   initial begin
      #1 resetn = 1'b0;
      #2;
      chk("rst_rf_wen", rf_wen, 1'b0);
      chk("rst_rf_wdata", rf_wdata, 32'd0);
      chk("rst_dbg_pc", debug_wb_pc, 32'd0);
      chk("rst_dbg_wen", debug_wb_rf_wen, 4'd0);
      chk("rst_dbg_wnum", debug_wb_rf_wnum, 5'd0);
      chk("rst_dbg_wdata", debug_wb_rf_wdata, 32'd0);
      chk("rst_retire", retire_cnt, 4'd0);
      @(posedge clk); @(posedge clk); #1 resetn = 1'b1;

      t = ld(32'hBFC0_0000, 5'd5, 32'h80FF_1234, 4'b0001, 2'b11, 1'b1);
      chk("model_lb", m_wdata(t), 32'hFFFF_FF80);
      slot(t, 0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FF80);
      chk("trace_lb_wnum", debug_wb_rf_wnum, 5'd5);
      chk("trace_lb_wdata", debug_wb_rf_wdata, 32'hFFFF_FF80);
      chk("trace_lb_wen", debug_wb_rf_wen, 4'hF);
      chk("trace_lb_pc", debug_wb_pc, 32'hBFC0_0000);

      t = ld(32'hBFC0_0004, 5'd6, 32'h8001_7FFF, 4'b0011, 2'b10, 1'b0);
      chk("model_lhu", m_wdata(t), 32'h0000_8001);
      slot(t, 0, 1'b0, 1'b1, 1'b1, 32'h0000_8001);
      slot(ld(32'hBFC0_0008, 5'd6, 32'h8001_7FFF, 4'b0011, 2'b00, 1'b1), 0, 1'b0, 1'b1, 1'b1, 32'h0000_7FFF);
      slot(ld(32'hBFC0_000C, 5'd7, 32'h8001_7FFF, 4'b0011, 2'b11, 1'b1), 0, 1'b0, 1'b1, 1'b1, 32'hFFFF_8001);
      slot(ld(32'hBFC0_0020, 5'd8, 32'h1234_A5C3, 4'b0001, 2'b00, 1'b1), 0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFC3);
      slot(ld(32'hBFC0_0024, 5'd8, 32'h1234_A5C3, 4'b0001, 2'b01, 1'b0), 0, 1'b0, 1'b1, 1'b1, 32'h0000_00A5);
      slot(ld(32'hBFC0_0028, 5'd8, 32'h1234_A5C3, 4'b0001, 2'b10, 1'b1), 0, 1'b0, 1'b1, 1'b1, 32'h0000_0034);
      slot(ld(32'hBFC0_002C, 5'd9, 32'hCAFE_F00D, 4'b1111, 2'b11, 1'b1), 0, 1'b0, 1'b1, 1'b1, 32'hCAFE_F00D);
      slot(ld(32'hBFC0_0030, 5'd9, 32'h8765_4321, 4'b0111, 2'b01, 1'b1), 0, 1'b0, 1'b1, 1'b1, 32'h8765_4321);

      t = base(32'hBFC0_0010, 5'd31, 32'h0000_0055);
      t.al = 1'b1;
      chk("model_jal", m_wdata(t), 32'hBFC0_0018);
      slot(t, 3, 1'b0, 1'b1, 1'b1, 32'hBFC0_0018);

      t = ld(32'hBFC0_0034, 5'd10, 32'h1111_2222, 4'b1111, 2'b00, 1'b0);
      t.req = 1'b0;
      slot(t, 1, 1'b0, 1'b1, 1'b0, 32'h1111_2222);
      slot(base(32'hBFC0_0038, 5'd0, 32'h0000_0077), 0, 1'b0, 1'b1, 1'b0, 32'h0000_0077);

      t = base(32'hBFC0_003C, 5'd11, 32'h0000_0001);
      t.hiloren = 2'b10; t.hilordata = 32'hDEAD_BEEF;
      slot(t, 0, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
      t = base(32'hBFC0_0040, 5'd12, 32'h0000_0002);
      t.cp0ren = 1'b1; t.cp0rdata = 32'h0000_0400; t.hiloren = 2'b01; t.hilordata = 32'h5555_5555;
      slot(t, 0, 1'b0, 1'b1, 1'b1, 32'h0000_0400);

      slot(base(32'hBFC0_0044, 5'd13, 32'hAAAA_0001), 1, 1'b1, 1'b1, 1'b1, 32'hAAAA_0001);
      slot(base(32'hBFC0_0048, 5'd14, 32'hAAAA_0002), 0, 1'b0, 1'b1, 1'b1, 32'hAAAA_0002);

      t = base(32'hBFC0_004C, 5'd0, 32'h0000_0000);
      t.regwen = 1'b0; t.eret = 1'b1;
      slot(t, 1, 1'b0, 1'b1, 1'b0, 32'h0000_0000);
      slot(base(RESET_PC, 5'd3, 32'h0000_0033), 2, 1'b0, 1'b1, 1'b0, 32'h0000_0033);

      // Reset while a slot is held.
      t = base(32'hBFC0_0100, 5'd7, 32'h0);
      t.al = 1'b1;
      cur = t; cur_first = 1'b1; stall = 1'b1;
      @(posedge clk); #1;
      cur_first = 1'b0;
      chk("held_wen", rf_wen, 1'b0);
      #1 resetn = 1'b0; cur_first = 1'b1;
      #1;
      chk("rstmid_retire", retire_cnt, 4'd0);
      chk("rstmid_dbg_pc", debug_wb_pc, 32'd0);
      chk("rstmid_dbg_wen", debug_wb_rf_wen, 4'd0);
      chk("rstmid_dbg_wnum", debug_wb_rf_wnum, 5'd0);
      chk("rstmid_dbg_wdata", debug_wb_rf_wdata, 32'd0);
      chk("rstmid_rf_wen", rf_wen, 1'b1);
      chk("rstmid_rf_wdata", rf_wdata, 32'hBFC0_0108);
      @(posedge clk); #1 resetn = 1'b1;
      @(posedge clk); #1;
      cur_first = 1'b0;
      chk("post_rst_retire", retire_cnt, 4'd1);
      stall = 1'b0;
      @(posedge clk); #1;

      for (int unsigned n = 0; n < 14; n++) begin
         t = base(32'hBFC0_0200 + 32'(n * 4), 5'(n + 1), 32'(n * 3));
         if (n % 3 == 0) begin t.regwen = 1'b0; t.eret = 1'b1; end
         slot(t, n % 2, 1'b0, 1'b0, 1'b0, 32'd0);
      end
      chk("retire_15", retire_cnt, 4'd15);
      slot(base(32'hBFC0_0300, 5'd20, 32'h0000_0099), 0, 1'b0, 1'b0, 1'b0, 32'd0);
      chk("retire_wrap", retire_cnt, 4'd0);

      cur = '0; cur_first = 1'b1;
      @(posedge clk); #1;
      @(negedge clk); #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage. Consumes the registered EC->WB segment outputs (wb_*).
- Aligns and extends load data, selects the writeback source, and drives the register-file write port.
- Guarantees each instruction writes back and retires exactly once, even while the segment is held by stall.
- Produces the difftest debug trace (registered) and a retired-instruction counter.

Parameters:
- RESET_PC, 32'h0000_0000, pc value of an empty/flushed slot; a slot whose wb_pc equals this is a bubble.
- CNT_W, 32, width of retire_cnt.

Ports:
- clk  in  1  core clock
- resetn  in  1  reset, asynchronous, active-low
- stall  in  1  same stall that drives the EC->WB segment; 1 = segment holds current contents
- refresh  in  1  same flush that drives the segment; segment loads zeros next edge
- wb_data_rdata  in  32  raw data-bus read word
- wb_pc  in  32  instruction pc
- wb_inst  in  32  instruction word (trace only)
- wb_res  in  32  ALU/address result
- wb_load  in  1  instruction is a load
- wb_loadX  in  1  1 = sign-extend load (LB/LH), 0 = zero-extend (LBU/LHU)
- wb_lsV  in  4  access size: 4'b0001 byte, 4'b0011 half, 4'b1111 word
- wb_data_addr  in  2  low address bits of the access
- wb_al  in  1  link instruction, writes wb_pc+8
- wb_regwen  in  1  instruction writes a GPR
- wb_wreg  in  5  destination GPR
- wb_data_req  in  1  load actually issued to the data bus
- wb_eret  in  1  ERET in slot (no GPR write)
- wb_cp0ren  in  1  MFC0 result valid
- wb_cp0rdata  in  32  CP0 read data
- wb_hiloren  in  2  2'b10 MFHI, 2'b01 MFLO, 2'b00 none
- wb_hilordata  in  32  HI/LO read data
- rf_wen  out  1  register-file write enable (combinational)
- rf_waddr  out  5  = wb_wreg
- rf_wdata  out  32  selected writeback data (combinational)
- debug_wb_pc  out  32  registered trace pc
- debug_wb_rf_wen  out  4  registered trace write enable, {4{rf_wen}}
- debug_wb_rf_wnum  out  5  registered trace dest
- debug_wb_rf_wdata  out  32  registered trace data
- retire_cnt  out  CNT_W  retired-instruction count

Behaviour:
- Slot valid: valid = (wb_pc != RESET_PC).
- done flag (internal), async reset 0. At each edge:
  - refresh or !stall -> done <= 0 (new contents arrive).
  - else if valid -> done <= 1.
  - First cycle of a slot therefore has done=0. Every further stalled cycle has done=1.
- Load data, using rotated byte lanes of wb_data_rdata selected by wb_data_addr:
  - byte: lane = addr[1:0], bit 7 sign/zero-extended per wb_loadX.
  - half: lane = addr[1] (addr[0] ignored; misalignment is trapped upstream), bit 15 extended.
  - word: whole word, addr ignored.
  - Any other lsV value: treat as word.
- rf_wdata priority: load -> aligned load data; else al -> wb_pc+8 (mod 2^32); else cp0ren -> wb_cp0rdata; else hiloren != 0 -> wb_hilordata; else wb_res.
- rf_wen = valid & wb_regwen & (wb_wreg != 0) & !done & !(wb_load & !wb_data_req).
  - A cancelled load never writes.
  - ERET never writes (regwen low upstream). rf_wen is not forced by eret.
- retire_cnt: async reset 0. +1 on the edge where valid & !done. Wraps at 2^CNT_W. Counts eret and bubble-free non-writing instructions.
- Debug registers, all async reset 0. On every edge:
  - debug_wb_pc <= (valid & !done) ? wb_pc : 0.
  - debug_wb_rf_wen <= {4{rf_wen}}.
  - debug_wb_rf_wnum <= rf_wen ? wb_wreg : 0.
  - debug_wb_rf_wdata <= rf_wen ? rf_wdata : 0.
  - Trace latency is 1 cycle after the rf write.
- Simultaneous refresh and stall: refresh wins; done clears.
- Reset mid-stall: done, counter and trace clear immediately; rf_wen follows the inputs combinationally.
- Reset outputs: debug_* = 0, retire_cnt = 0. rf_* are combinational, so with zeroed inputs rf_wen = 0 and rf_wdata = 0.

Test Plan:
- LB, addr=2'b11, rdata=32'h80FF_1234, loadX=1, wreg=5 -> rf_wdata=32'hFFFF_FF80, rf_wen=1 for 1 cycle; trace shows wnum 5 and data FFFFFF80 the next cycle.
- LHU, addr=2'b10, rdata=32'h8001_7FFF, loadX=0 -> rf_wdata=32'h0000_8001. LH with addr=2'b00 -> 32'h0000_7FFF.
- JAL at pc=32'hBFC0_0010, al=1, wreg=31, held with stall=1 for 3 cycles -> rf_wen high only in the first cycle, rf_wdata=32'hBFC0_0018, retire_cnt +1 exactly once.
- Load with wb_data_req=0, regwen=1 -> rf_wen=0, and retire_cnt still increments. wreg=0 with regwen=1 -> rf_wen=0.
- MFHI (hiloren=2'b10, hilordata=32'hDEAD_BEEF) and MFC0 (cp0ren=1, cp0rdata=32'h0000_0400) back-to-back -> rf_wdata matches each in turn. Refresh asserted together with stall -> the next slot writes again (done cleared).
- retire_cnt preset near wrap (CNT_W=4, 15 retirements) plus 1 more -> count reads 0. resetn low mid-stall -> counter and all debug outputs read 0 immediately.
